// File: rtl/miner_pkg.sv
// Shared types and constants for the miner datapath: scheduler states, message/digest widths
// and the SHA-256 initial hash words used by the core.
package miner_pkg;

  localparam int unsigned SHA_MSG_W    = 440;
  localparam int unsigned SHA_DIGEST_W = 256;
  localparam int unsigned NONCE_W      = 32;
  localparam int unsigned PREFIX_W     = SHA_MSG_W - NONCE_W;

  // H0 sits in the top word, H7 in word 0.
  localparam logic [7:0][31:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StCheck,
    StHit,
    StExh,
    StFault
  } sched_state_t;

endpackage

// File: rtl/hash_target_compare.sv
// Registered unsigned a < b, split into slices so each register stage sees a short compare;
// the result is valid one cycle after the operands.
module hash_target_compare
  import miner_pkg::*;
#(
  parameter int unsigned Width  = SHA_DIGEST_W,
  parameter int unsigned SliceW = 64
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             lt_o
);

  localparam int unsigned NumSlices = Width / SliceW;

  logic [NumSlices-1:0] lt_d, lt_q, eq_d, eq_q;

  always_comb begin
    lt_d = '0;
    eq_d = '0;
    for (int s = 0; s < NumSlices; s++) begin
      lt_d[s] = a_i[s*SliceW +: SliceW] <  b_i[s*SliceW +: SliceW];
      eq_d[s] = a_i[s*SliceW +: SliceW] == b_i[s*SliceW +: SliceW];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lt_q <= '0;
      eq_q <= '0;
    end else begin
      lt_q <= lt_d;
      eq_q <= eq_d;
    end
  end

  // Most significant unequal slice decides; all-equal is not less-than.
  always_comb begin
    lt_o = 1'b0;
    for (int s = 0; s < NumSlices; s++) begin
      if (!eq_q[s]) lt_o = lt_q[s];
    end
  end

endmodule

// File: rtl/nonce_sweep_scheduler.sv
// Walks the SHA core across an inclusive (wrapping) nonce range, stopping on the first digest
// below target, range exhaustion, abort or a core timeout.
module nonce_sweep_scheduler
  import miner_pkg::*;
#(
  parameter int unsigned PrefixW       = PREFIX_W,
  parameter int unsigned NonceW        = NONCE_W,
  parameter int unsigned TimeoutCycles = 1023
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [PrefixW-1:0]        msg_prefix_i,
  input  logic [NonceW-1:0]         nonce_first_i,
  input  logic [NonceW-1:0]         nonce_last_i,
  input  logic [SHA_DIGEST_W-1:0]   target_i,
  output logic [PrefixW+NonceW-1:0] sha_msg_o,
  output logic                      sha_begin_o,
  input  logic                      sha_done_i,
  input  logic [SHA_DIGEST_W-1:0]   sha_hash_i,
  output logic                      busy_o,
  output logic                      found_o,
  output logic [NonceW-1:0]         found_nonce_o,
  output logic [SHA_DIGEST_W-1:0]   found_hash_o,
  output logic                      exhausted_o,
  output logic                      fault_o,
  output logic [NonceW:0]           hash_count_o
);

  localparam int unsigned TimerW = $clog2(TimeoutCycles + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutCycles - 1);

  sched_state_t              state_d, state_q;
  logic [PrefixW-1:0]        prefix_d, prefix_q;
  logic [NonceW-1:0]         nonce_d, nonce_q;
  logic [NonceW-1:0]         last_d, last_q;
  logic [SHA_DIGEST_W-1:0]   target_d, target_q;
  logic [SHA_DIGEST_W-1:0]   hash_d, hash_q;
  logic [TimerW-1:0]         timer_d, timer_q;
  logic [NonceW:0]           count_d, count_q;
  logic                      found_d, found_q;
  logic                      exh_d, exh_q;
  logic                      fault_d, fault_q;
  logic [NonceW-1:0]         found_nonce_d, found_nonce_q;
  logic [SHA_DIGEST_W-1:0]   found_hash_d, found_hash_q;
  logic                      hash_lt;

  // Fed straight from the core so the registered verdict is ready during CHECK.
  hash_target_compare #(
    .Width  (SHA_DIGEST_W),
    .SliceW (64)
  ) u_cmp (
    .clk   (clk),
    .n_rst (n_rst),
    .a_i   (sha_hash_i),
    .b_i   (target_q),
    .lt_o  (hash_lt)
  );

  always_comb begin
    state_d       = state_q;
    prefix_d      = prefix_q;
    nonce_d       = nonce_q;
    last_d        = last_q;
    target_d      = target_q;
    hash_d        = hash_q;
    timer_d       = timer_q;
    count_d       = count_q;
    found_d       = found_q;
    exh_d         = exh_q;
    fault_d       = fault_q;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;

    if (abort_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            prefix_d = msg_prefix_i;
            nonce_d  = nonce_first_i;
            last_d   = nonce_last_i;
            target_d = target_i;
            count_d  = '0;
            found_d  = 1'b0;
            exh_d    = 1'b0;
            fault_d  = 1'b0;
            state_d  = StLaunch;
          end
        end
        StLaunch: begin
          timer_d = '0;
          state_d = StWait;
        end
        StWait: begin
          if (sha_done_i) begin
            hash_d  = sha_hash_i;
            count_d = count_q + 1'b1;
            state_d = StCheck;
          end else if (timer_q == TimerLast) begin
            fault_d = 1'b1;
            state_d = StFault;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StCheck: begin
          if (hash_lt) begin
            found_nonce_d = nonce_q;
            found_hash_d  = hash_q;
            found_d       = 1'b1;
            state_d       = StHit;
          end else if (nonce_q == last_q) begin
            exh_d   = 1'b1;
            state_d = StExh;
          end else begin
            nonce_d = nonce_q + 1'b1;
            state_d = StLaunch;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= StIdle;
      prefix_q      <= '0;
      nonce_q       <= '0;
      last_q        <= '0;
      target_q      <= '0;
      hash_q        <= '0;
      timer_q       <= '0;
      count_q       <= '0;
      found_q       <= 1'b0;
      exh_q         <= 1'b0;
      fault_q       <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
    end else begin
      state_q       <= state_d;
      prefix_q      <= prefix_d;
      nonce_q       <= nonce_d;
      last_q        <= last_d;
      target_q      <= target_d;
      hash_q        <= hash_d;
      timer_q       <= timer_d;
      count_q       <= count_d;
      found_q       <= found_d;
      exh_q         <= exh_d;
      fault_q       <= fault_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
    end
  end

  assign sha_msg_o     = {prefix_q, nonce_q};
  assign sha_begin_o   = (state_q == StLaunch);
  assign busy_o        = (state_q == StLaunch) || (state_q == StWait) || (state_q == StCheck);
  assign found_o       = found_q;
  assign found_nonce_o = found_nonce_q;
  assign found_hash_o  = found_hash_q;
  assign exhausted_o   = exh_q;
  assign fault_o       = fault_q;
  assign hash_count_o  = count_q;

endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// Bench for nonce_sweep_scheduler: a latency-programmable core model, a sweep planner that
// predicts the launched nonces and the outcome, and a per-cycle message checker.
module tb_nonce_sweep_scheduler;

  localparam int unsigned PW = 408;
  localparam int unsigned NW = 32;
  localparam int unsigned DW = 256;
  localparam int unsigned MW = 440;
  localparam int unsigned TO = 1023;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start, abort;
  logic [PW-1:0] prefix;
  logic [NW-1:0] nf, nl;
  logic [DW-1:0] tgt;
  logic [MW-1:0] sha_msg;
  logic          sha_begin, sha_done;
  logic [DW-1:0] sha_hash;
  logic          busy, found, exhausted, fault;
  logic [NW-1:0] found_nonce;
  logic [DW-1:0] found_hash;
  logic [NW:0]   hash_count;

  always #5 clk = ~clk;

  nonce_sweep_scheduler dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start_i       (start),
    .abort_i       (abort),
    .msg_prefix_i  (prefix),
    .nonce_first_i (nf),
    .nonce_last_i  (nl),
    .target_i      (tgt),
    .sha_msg_o     (sha_msg),
    .sha_begin_o   (sha_begin),
    .sha_done_i    (sha_done),
    .sha_hash_i    (sha_hash),
    .busy_o        (busy),
    .found_o       (found),
    .found_nonce_o (found_nonce),
    .found_hash_o  (found_hash),
    .exhausted_o   (exhausted),
    .fault_o       (fault),
    .hash_count_o  (hash_count)
  );

  int checks = 0;
  int errors = 0;

  // Core behaviour knobs
  int            core_lat  = 2;
  bit            core_mute = 1'b0;
  bit            hit_en    = 1'b0;
  logic [NW-1:0] hit_nonce = '0;
  logic [DW-1:0] hit_hash  = '0;
  logic [DW-1:0] miss_hash = '0;

  // Model expectations
  logic [NW-1:0] exp_q[$];
  bit            exp_found, exp_exh;
  logic [NW-1:0] exp_fnonce;
  logic [DW-1:0] exp_fhash;
  int            begins = 0;
  int            base   = 0;
  logic [NW-1:0] seen[$];

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] core_hash(input logic [NW-1:0] n);
    return (hit_en && n == hit_nonce) ? hit_hash : miss_hash;
  endfunction

  // Walk the range the way the sweep is defined: first hit wins, last nonce ends a miss run.
  task automatic plan(input logic [NW-1:0] first, input logic [NW-1:0] last,
                      input logic [DW-1:0] t);
    logic [NW-1:0] n;
    n = first;
    exp_q.delete();
    exp_found = 1'b0;
    exp_exh   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(n);
      if (core_hash(n) < t) begin
        exp_found  = 1'b1;
        exp_fnonce = n;
        exp_fhash  = core_hash(n);
        break;
      end
      if (n == last) begin
        exp_exh = 1'b1;
        break;
      end
      n = n + 1;
    end
  endtask

  // Core model: answers each sha_begin after core_lat cycles.
  initial begin : core_model
    int            cnt;
    bit            pend;
    logic [NW-1:0] n;
    pend     = 1'b0;
    cnt      = 0;
    n        = '0;
    sha_done = 1'b0;
    sha_hash = '0;
    forever begin
      @(negedge clk);
      sha_done = 1'b0;
      if (!n_rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            sha_done = !core_mute;
            sha_hash = core_hash(n);
            pend     = 1'b0;
          end
        end
        if (sha_begin) begin
          n    = sha_msg[NW-1:0];
          pend = 1'b1;
          cnt  = core_lat;
        end
      end
    end
  end

  // Per-cycle check of the core message while the scheduler is busy.
  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      if (sha_begin) begin
        if (begins - base < exp_q.size())
          chk("launch_msg", sha_msg, {prefix, exp_q[begins-base]});
        else
          chk("launch_count", MW'(begins - base + 1), MW'(exp_q.size()));
        seen.push_back(sha_msg[NW-1:0]);
        begins++;
      end else if (busy && begins > base && begins - base <= exp_q.size()) begin
        chk("msg_hold", sha_msg, {prefix, exp_q[begins-base-1]});
      end
    end
  end

  task automatic do_start(input logic [PW-1:0] p, input logic [NW-1:0] f, input logic [NW-1:0] l,
                          input logic [DW-1:0] t);
    @(negedge clk);
    prefix = p;
    nf     = f;
    nl     = l;
    tgt    = t;
    plan(f, l, t);
    base  = begins;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int limit);
    int n;
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_terminates", MW'(busy), MW'(0));
  endtask

  task automatic check_outcome(input string tag);
    chk({tag, "_found"}, MW'(found), MW'(exp_found));
    chk({tag, "_exhausted"}, MW'(exhausted), MW'(exp_exh));
    chk({tag, "_fault"}, MW'(fault), MW'(0));
    chk({tag, "_hash_count"}, MW'(hash_count), MW'(exp_q.size()));
    chk({tag, "_launches"}, MW'(begins - base), MW'(exp_q.size()));
    if (exp_found) begin
      chk({tag, "_found_nonce"}, MW'(found_nonce), MW'(exp_fnonce));
      chk({tag, "_found_hash"}, MW'(found_hash), MW'(exp_fhash));
    end
    repeat (2) @(negedge clk);
    chk({tag, "_flags_held"}, MW'({found, exhausted, fault, busy}),
        MW'({exp_found, exp_exh, 1'b0, 1'b0}));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sha_msg"}, sha_msg, '0);
    chk({tag, "_ctrl"}, MW'({sha_begin, busy, found, exhausted, fault}), '0);
    chk({tag, "_found_nonce"}, MW'(found_nonce), '0);
    chk({tag, "_found_hash"}, MW'(found_hash), '0);
    chk({tag, "_hash_count"}, MW'(hash_count), '0);
  endtask

  initial begin : main
    logic [DW-1:0] t;
    logic [NW-1:0] wrap_exp[4];
    int            n, k;
    start  = 1'b0;
    abort  = 1'b0;
    prefix = '0;
    nf     = '0;
    nl     = '0;
    tgt    = '0;
    n_rst  = 1'b1;
    #1 n_rst = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    // Hit on the second nonce
    hit_en    = 1'b1;
    hit_nonce = 32'd6;
    hit_hash  = 256'h1;
    miss_hash = '1;
    do_start({51{8'hA5}}, 32'd5, 32'd9, {1'b1, 255'b0});
    wait_end(200);
    check_outcome("hit");
    chk("hit_nonce_lit", MW'(found_nonce), MW'(32'd6));
    chk("hit_count_lit", MW'(hash_count), MW'(2));
    chk("hit_launch_lit", MW'(begins - base), MW'(2));

    // Single-nonce range, zero target
    hit_en    = 1'b0;
    miss_hash = 256'h0;
    do_start({51{8'h3C}}, 32'h10, 32'h10, '0);
    wait_end(200);
    check_outcome("exh");
    chk("exh_count_lit", MW'(hash_count), MW'(1));

    // Wrap through 0xFFFFFFFF
    miss_hash = {64{4'h9}};
    do_start({51{8'h5A}}, 32'hFFFF_FFFE, 32'h0000_0001, '0);
    wait_end(200);
    check_outcome("wrap");
    chk("wrap_count_lit", MW'(hash_count), MW'(4));
    wrap_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    for (int i = 0; i < 4; i++) begin
      if (base + i < seen.size()) chk("wrap_nonce_lit", MW'(seen[base+i]), MW'(wrap_exp[i]));
      else chk("wrap_nonce_seen", MW'(seen.size()), MW'(base + 4));
    end

    // Equality is a miss, one below is a hit
    t         = {64'h0000_0000_1234_5678, 64'h9ABC_DEF0_0000_0000, 64'h0, 64'h0};
    miss_hash = t;
    do_start({51{8'hC3}}, 32'd7, 32'd7, t);
    wait_end(200);
    check_outcome("eq_miss");
    miss_hash = t - 1;
    do_start({51{8'hC3}}, 32'd7, 32'd7, t);
    wait_end(200);
    check_outcome("eq_minus1_hit");
    chk("eq_minus1_nonce_lit", MW'(found_nonce), MW'(32'd7));

    // Silent core: fault after exactly TO cycles in WAIT
    core_mute = 1'b1;
    do_start({51{8'h11}}, 32'd0, 32'd3, '1);
    n = 0;
    while (fault !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("fault_latency", MW'(n - 1), MW'(TO));
    chk("fault_flags", MW'({fault, found, exhausted, busy}), MW'(4'b1000));
    chk("fault_hash_count", MW'(hash_count), '0);
    core_mute = 1'b0;

    // Abort in the third WAIT; the core's late done must be ignored
    core_lat  = 4;
    miss_hash = '1;
    do_start({51{8'h77}}, 32'd0, 32'd9, '0);
    k = 1;
    n = 0;
    while (k < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (sha_begin) k++;
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_state", MW'({busy, found, exhausted, fault}), '0);
    chk("abort_hash_count", MW'(hash_count), MW'(2));
    chk("abort_launches", MW'(begins - base), MW'(3));

    // Abort beats start in the same cycle
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_vs_start_busy", MW'(busy), '0);
    chk("abort_vs_start_launches", MW'(begins - base), MW'(3));
    chk("abort_vs_start_count", MW'(hash_count), MW'(2));

    // Reset during the second WAIT clears everything immediately
    do_start({51{8'hE1}}, 32'h100, 32'h1FF, '0);
    k = 1;
    n = 0;
    while (k < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (sha_begin) k++;
    end
    @(negedge clk);
    chk("pre_reset_count", MW'(hash_count), MW'(1));
    #2 n_rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_idle", MW'({busy, sha_begin}), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
